// File: rtl/axi4lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_pkg
// Description : Shared constants and helpers for the AXI4-Lite register slave
//               (response codes, default widths, register indices).
// Revision    : 1.0 - initial release
// ============================================================================
package axi4lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  // Register indices of the default 4-entry file
  localparam int REG_IDX_0 = 0;
  localparam int REG_IDX_1 = 1;
  localparam int REG_IDX_2 = 2;
  localparam int REG_IDX_3 = 3;

  // Map an access-error flag onto the AXI response code
  function automatic axi_resp_t resp_for(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_regfile.sv
`default_nettype none
// ============================================================================
// Module      : axil_regfile
// Description : Register array behind the AXI4-Lite slave. One write port with
//               per-byte strobes, one asynchronous read port, flattened view.
//               Macro AXIL_RO_STATUS_EN turns the last register into a
//               read-only counter that advances on each status_inc pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_regfile
  import axi4lite_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int STRB_W = DATA_W / 8,
  localparam int NREGS  = 2 ** ADDR_W
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [STRB_W-1:0]       wr_strb,
`ifdef AXIL_RO_STATUS_EN
  input  logic                    status_inc,
`endif
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [DATA_W-1:0]       rd_data,
  output logic [NREGS*DATA_W-1:0] regs
);

  logic [DATA_W-1:0] reg_arr [NREGS];

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    logic [DATA_W-1:0] word;

`ifdef AXIL_RO_STATUS_EN
    if (i == NREGS - 1) begin : g_status
      logic [DATA_W-1:0] cnt;
      // Completed-write counter; wraps naturally at the top of its range
      always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn)  cnt <= '0;
        else if (status_inc) cnt <= cnt + 1'b1;
      end
      assign word = cnt;
    end else begin : g_rw
      for (genvar b = 0; b < STRB_W; b++) begin : g_lane
        logic [7:0] q;
        // Byte lane loads when its register is addressed and its strobe is set
        always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
          if (!m_axi_aresetn) q <= RESET_VAL[b*8 +: 8];
          else if (wr_en && (wr_addr == ADDR_W'(i)) && wr_strb[b]) q <= wr_data[b*8 +: 8];
        end
        assign word[b*8 +: 8] = q;
      end
    end
`else
    for (genvar b = 0; b < STRB_W; b++) begin : g_lane
      logic [7:0] q;
      // Byte lane loads when its register is addressed and its strobe is set
      always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) q <= RESET_VAL[b*8 +: 8];
        else if (wr_en && (wr_addr == ADDR_W'(i)) && wr_strb[b]) q <= wr_data[b*8 +: 8];
      end
      assign word[b*8 +: 8] = q;
    end
`endif

    assign reg_arr[i]                 = word;
    assign regs[i*DATA_W +: DATA_W]   = word;
  end

  assign rd_data = reg_arr[rd_addr];

endmodule
`default_nettype wire

// File: rtl/axi4lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_slave_regs
// Description : AXI4-Lite slave fronting a small register file. AW and W are
//               captured independently into holding registers; the write
//               commits the cycle after both are held. Reads return data one
//               cycle after the AR handshake. All outputs are registered.
//               Macro AXIL_RO_STATUS_EN makes the last register a read-only
//               write counter; writes to it answer SLVERR.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_slave_regs
  import axi4lite_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int STRB_W = DATA_W / 8,
  localparam int NREGS  = 2 ** ADDR_W
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic [ADDR_W-1:0]       s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_W-1:0]       s_axi_wdata,
  input  logic [STRB_W-1:0]       s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_W-1:0]       s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_W-1:0]       s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [NREGS*DATA_W-1:0] regs_o
);

  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire, commit, wr_err;
  logic aw_held_nx, w_held_nx, bvalid_nx, rvalid_nx;
  logic [DATA_W-1:0] rd_data;

  // Handshake decode and next-state of the holding flags / valids
  always_comb begin
    aw_fire = s_axi_awvalid && s_axi_awready;
    w_fire  = s_axi_wvalid  && s_axi_wready;
    b_fire  = s_axi_bvalid  && s_axi_bready;
    ar_fire = s_axi_arvalid && s_axi_arready;
    r_fire  = s_axi_rvalid  && s_axi_rready;
    // Both halves held implies bvalid is low: neither half is accepted while it is high
    commit  = aw_held && w_held;

    aw_held_nx = aw_held;
    if (commit)       aw_held_nx = 1'b0;
    else if (aw_fire) aw_held_nx = 1'b1;

    w_held_nx = w_held;
    if (commit)      w_held_nx = 1'b0;
    else if (w_fire) w_held_nx = 1'b1;

    bvalid_nx = s_axi_bvalid;
    if (commit)      bvalid_nx = 1'b1;
    else if (b_fire) bvalid_nx = 1'b0;

    rvalid_nx = s_axi_rvalid;
    if (ar_fire)     rvalid_nx = 1'b1;
    else if (r_fire) rvalid_nx = 1'b0;
  end

`ifdef AXIL_RO_STATUS_EN
  assign wr_err = (aw_addr_q == ADDR_W'(NREGS - 1));
`else
  assign wr_err = 1'b0;
`endif

  // Write channel: capture AW/W, commit, and hold B until accepted
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      if (aw_fire) aw_addr_q <= s_axi_awaddr;
      if (w_fire) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (commit) s_axi_bresp <= resp_for(wr_err);
      aw_held       <= aw_held_nx;
      w_held        <= w_held_nx;
      s_axi_bvalid  <= bvalid_nx;
      s_axi_awready <= !aw_held_nx && !bvalid_nx;
      s_axi_wready  <= !w_held_nx  && !bvalid_nx;
    end
  end

  // Read channel: sample the register on AR, hold R until accepted
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_arready <= 1'b1;
    end else begin
      if (ar_fire) begin
        s_axi_rdata <= rd_data;
        s_axi_rresp <= RESP_OKAY;
      end
      s_axi_rvalid  <= rvalid_nx;
      s_axi_arready <= !rvalid_nx;
    end
  end

  axil_regfile #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .m_axi_aclk    (m_axi_aclk),
    .m_axi_aresetn (m_axi_aresetn),
    .wr_en         (commit && !wr_err),
    .wr_addr       (aw_addr_q),
    .wr_data       (w_data_q),
    .wr_strb       (w_strb_q),
`ifdef AXIL_RO_STATUS_EN
    .status_inc    (b_fire),
`endif
    .rd_addr       (s_axi_araddr),
    .rd_data       (rd_data),
    .regs          (regs_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4lite_slave_regs
// Description : Self-checking bench for axi4lite_slave_regs: directed cases
//               followed by randomized reads/writes against a register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4lite_slave_regs;
  import axi4lite_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int NREGS  = 4;
`ifdef AXIL_RO_STATUS_EN
  localparam bit RO = 1'b1;
`else
  localparam bit RO = 1'b0;
`endif

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic [0:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [DATA_W-1:0] rdata;
  logic [NREGS*DATA_W-1:0] regs_o;

  always #5 clk = ~clk;

  axi4lite_slave_regs dut (
    .m_axi_aclk(clk), .m_axi_aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .regs_o(regs_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: plain register array plus count of completed writes
  logic [7:0] model_regs [NREGS];
  int         model_wcount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_status(input int addr);
    return RO && (addr == NREGS - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
    model_wcount = 0;
  endtask

  function automatic logic [1:0] model_bresp(input int addr);
    return is_status(addr) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [7:0] model_read(input int addr);
    logic [31:0] c;
    c = model_wcount;
    return is_status(addr) ? c[7:0] : model_regs[addr];
  endfunction

  task automatic model_write(input int addr, input logic [7:0] data, input logic strb);
    if (!is_status(addr) && strb) model_regs[addr] = data;
    model_wcount++;
  endtask

  function automatic logic [31:0] model_flat();
    logic [31:0] f;
    for (int i = 0; i < NREGS; i++) f[i*8 +: 8] = model_read(i);
    return f;
  endfunction

  // One write with independent AW/W start delays and a B-ready delay
  task automatic do_write(input logic [1:0] addr, input logic [7:0] data, input logic strb,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp, output int lat, output int hold_err);
    bit aw_done = 0, w_done = 0, b_done = 0;
    int cyc = 0, last_fire = -1, b_first = -1, b_wait = 0;
    resp = 2'b11; hold_err = 0;
    while (!b_done && cyc < 60) begin
      @(negedge clk);
      if (w_done && !aw_done && wready !== 1'b0) hold_err++;
      if (aw_done && !w_done && awready !== 1'b0) hold_err++;
      if (bvalid === 1'b1 && (awready !== 1'b0 || wready !== 1'b0)) hold_err++;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done  && (cyc >= w_dly);
      bready  = 1'b0;
      if (bvalid === 1'b1) begin
        if (b_first < 0) b_first = cyc;
        if (b_wait >= b_dly) begin bready = 1'b1; resp = bresp; b_done = 1; end
        else b_wait++;
      end
      if (awvalid && awready) begin aw_done = 1; last_fire = cyc; end
      if (wvalid && wready)   begin w_done = 1;  last_fire = cyc; end
      cyc++;
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    if (!b_done) chk("write_timeout", 32'd0, 32'd1);
    lat = (b_first >= 0 && last_fire >= 0) ? (b_first - last_fire) : -1;
  endtask

  // One read with AR start delay and R-ready delay; checks R stability while stalled
  task automatic do_read(input logic [1:0] addr, input int ar_dly, input int r_dly,
                         output logic [7:0] data, output logic [1:0] resp, output int lat,
                         output int stable_err, output logic arready_after);
    bit ar_done = 0, r_done = 0;
    int cyc = 0, fire = -1, r_first = -1, r_wait = 0;
    logic [7:0] first_data;
    data = 'x; resp = 2'b11; stable_err = 0; first_data = '0;
    while (!r_done && cyc < 60) begin
      @(negedge clk);
      araddr = addr;
      arvalid = !ar_done && (cyc >= ar_dly);
      rready = 1'b0;
      if (rvalid === 1'b1) begin
        if (r_first < 0) begin r_first = cyc; first_data = rdata; end
        else if (rdata !== first_data) stable_err++;
        if (arready !== 1'b0) stable_err++;
        if (r_wait >= r_dly) begin rready = 1'b1; data = rdata; resp = rresp; r_done = 1; end
        else r_wait++;
      end
      if (arvalid && arready) begin ar_done = 1; fire = cyc; end
      cyc++;
    end
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b0;
    arready_after = arready;
    if (!r_done) chk("read_timeout", 32'd0, 32'd1);
    lat = (r_first >= 0 && fire >= 0) ? (r_first - fire) : -1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, awready, 1);
    chk({tag, "_wready"},  wready,  1);
    chk({tag, "_arready"}, arready, 1);
    chk({tag, "_bvalid"},  bvalid,  0);
    chk({tag, "_rvalid"},  rvalid,  0);
    chk({tag, "_bresp"},   bresp,   0);
    chk({tag, "_rresp"},   rresp,   0);
    chk({tag, "_rdata"},   rdata,   0);
    chk({tag, "_regs"},    regs_o,  0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    logic [7:0] rd, old;
    logic       ar_after;
    int lat, herr, serr, extra;

    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    aresetn = 1'b1;

    // Write A5 to addr 1: AW first, W one cycle later, bready ready at once
    do_write(2'd1, 8'hA5, 1'b1, 0, 1, 0, resp, lat, herr);
    model_write(1, 8'hA5, 1'b1);
    chk("t1_bresp", resp, model_bresp(1));
    chk("t1_lat", lat, 2);
    chk("t1_reg1", regs_o[15:8], 8'hA5);

    // W three cycles ahead of AW to addr 2
    do_write(2'd2, 8'h3C, 1'b1, 3, 0, 0, resp, lat, herr);
    model_write(2, 8'h3C, 1'b1);
    chk("t2_bresp", resp, model_bresp(2));
    chk("t2_hold", herr, 0);
    chk("t2_regs", regs_o, model_flat());
    extra = 0;
    repeat (3) begin @(negedge clk); if (bvalid !== 1'b0) extra++; end
    chk("t2_single_b", extra, 0);

    // Read addr 1 with rready held off 4 cycles
    do_read(2'd1, 0, 4, rd, resp, lat, serr, ar_after);
    chk("t3_rdata", rd, 8'hA5);
    chk("t3_rresp", resp, 0);
    chk("t3_lat", lat, 1);
    chk("t3_stable", serr, 0);
    chk("t3_arready_back", ar_after, 1);

    // Strobe clear: addr 0 unchanged
    do_write(2'd0, 8'hFF, 1'b0, 0, 0, 1, resp, lat, herr);
    model_write(0, 8'hFF, 1'b0);
    chk("t4_bresp", resp, 0);
    chk("t4_reg0", regs_o[7:0], 8'h00);

    // Read and write of addr 0 land on the same edge: read sees old value
    old = model_read(0);
    @(negedge clk);
    chk("t5_ready", {awready, wready}, 2'b11);
    awaddr = 2'd0; wdata = 8'h5A; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; araddr = 2'd0; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("t5_rvalid", rvalid, 1);
    chk("t5_bvalid", bvalid, 1);
    chk("t5_rdata_old", rdata, old);
    rready = 1'b1; bready = 1'b1;
    model_write(0, 8'h5A, 1'b1);
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    chk("t5_regs", regs_o, model_flat());

    // Reset with AW held and R pending
    awaddr = 2'd2; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; araddr = 2'd1; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("t6_pre_rvalid", rvalid, 1);
    chk("t6_pre_awready", awready, 0);
    #2 aresetn = 1'b0;
    #1 chk_reset_outputs("t6_async");
    model_reset();
    @(negedge clk);
    aresetn = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b1) extra++;
    end
    chk("t6_no_stray", extra, 0);

    // Three writes then one to the top register
    for (int k = 0; k < 3; k++) begin
      do_write(2'(k), 8'(8'h10 + k), 1'b1, k, 0, 0, resp, lat, herr);
      model_write(k, 8'(8'h10 + k), 1'b1);
      chk("t7_bresp", resp, 0);
    end
    do_write(2'd3, 8'hEE, 1'b1, 0, 0, 0, resp, lat, herr);
    model_write(3, 8'hEE, 1'b1);
    chk("t7_top_bresp", resp, RO ? 32'd2 : 32'd0);
    do_read(2'd3, 0, 0, rd, resp, lat, serr, ar_after);
    chk("t7_top_rdata", rd, RO ? 32'h04 : 32'hEE);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      int a;
      a = $urandom_range(0, NREGS - 1);
      if ($urandom_range(0, 1) == 0) begin
        logic [7:0] d;
        logic s;
        logic [1:0] exp_resp;
        d = 8'($urandom);
        s = ($urandom_range(0, 3) != 0);
        exp_resp = model_bresp(a);
        do_write(2'(a), d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), resp, lat, herr);
        model_write(a, d, s);
        chk("rnd_bresp", resp, exp_resp);
        chk("rnd_wlat", lat, 2);
        chk("rnd_whold", herr, 0);
        chk("rnd_regs", regs_o, model_flat());
      end else begin
        logic [7:0] exp_d;
        exp_d = model_read(a);
        do_read(2'(a), $urandom_range(0, 3), $urandom_range(0, 3), rd, resp, lat, serr, ar_after);
        chk("rnd_rdata", rd, exp_d);
        chk("rnd_rresp", resp, 0);
        chk("rnd_rlat", lat, 1);
        chk("rnd_rstable", serr, 0);
        chk("rnd_arready", ar_after, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
